// File: rtl/alu_result_if.sv
// Handshake and flag bus around the ALU result stage.
// The upstream adder and downstream consumer use "master"; the stage uses "slave".
interface alu_result_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             mode;
    logic             a_msb;
    logic             b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             sticky_v;
    logic             clr_sticky;
    logic [CNT_W-1:0] res_count;

    modport slave (
        input  in_valid, sum, carry, mode, a_msb, b_msb, out_ready, clr_sticky,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v,
               sticky_v, res_count
    );

    modport master (
        output in_valid, sum, carry, mode, a_msb, b_msb, out_ready, clr_sticky,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v,
               sticky_v, res_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered result/flag stage behind the 4-bit adder/subtractor: computes Z/N/C/V
// at push time, buffers entries in a small FIFO, tracks sticky overflow and delivery count.
module alu_result_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    alu_result_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam int ENT_W = WIDTH + 4;

    // entry layout: {z, n, c, v, sum}
    logic [ENT_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_BITS-1:0] count;
    logic [ENT_W-1:0]    entry_in;
    logic [ENT_W-1:0]    head;
    logic                push;
    logic                pop;
    logic                sticky;
    logic [CNT_W-1:0]    delivered;
    logic                fz;
    logic                fn;
    logic                fc;
    logic                fv;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends only on registered count and reset, never on out_ready
    assign bus.in_ready  = rst_n && (count != CNT_BITS'(DEPTH));
    assign bus.out_valid = (count != '0);

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // subtract: carry=1 means no borrow, so C is the inverted carry
    assign fz = (bus.sum == '0);
    assign fn = bus.sum[WIDTH-1];
    assign fc = bus.carry ^ bus.mode;
    assign fv = (bus.a_msb == (bus.b_msb ^ bus.mode)) && (bus.sum[WIDTH-1] != bus.a_msb);
    assign entry_in = {fz, fn, fc, fv, bus.sum};

    assign head          = mem[rd_ptr];
    assign bus.result    = head[WIDTH-1:0];
    assign bus.flag_v    = head[WIDTH];
    assign bus.flag_c    = head[WIDTH+1];
    assign bus.flag_n    = head[WIDTH+2];
    assign bus.flag_z    = head[WIDTH+3];
    assign bus.sticky_v  = sticky;
    assign bus.res_count = delivered;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            sticky    <= 1'b0;
            delivered <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry_in;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= next_ptr(rd_ptr);
                delivered <= delivered + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // a V=1 delivery beats a coincident clear
            if (pop && head[WIDTH]) begin
                sticky <= 1'b1;
            end else if (bus.clr_sticky) begin
                sticky <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected entries come from an independent
// arithmetic model of the adder and are compared as the stage delivers them.
module tb_alu_result_stage;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [7:0] q[$];
    logic       m_sticky;
    logic [7:0] m_count;

    alu_result_if #(.WIDTH(4), .CNT_W(8)) bus ();

    alu_result_stage #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected {result, z, n, c, v} from signed/unsigned arithmetic on the operands
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic m);
        int sa;
        int sb;
        int r;
        logic [3:0] res;
        logic c;
        logic v;
        sa  = a[3] ? int'(a) - 16 : int'(a);
        sb  = b[3] ? int'(b) - 16 : int'(b);
        r   = m ? sa - sb : sa + sb;
        v   = (r > 7) || (r < -8);
        c   = m ? (a < b) : ((int'(a) + int'(b)) > 15);
        res = m ? a - b : a + b;
        return {res, (res == 4'd0), res[3], c, v};
    endfunction

    // one cycle: called at negedge, returns at the next negedge
    task automatic step(input logic iv, input logic [3:0] a, input logic [3:0] b,
                        input logic m, input logic ordy, input logic clr);
        logic [4:0] full;
        logic [7:0] got;
        logic [7:0] popped;
        logic       do_pop;
        logic       do_push;
        full = m ? ({1'b0, a} + {1'b0, ~b} + 5'd1) : ({1'b0, a} + {1'b0, b});
        bus.in_valid   = iv;
        bus.sum        = full[3:0];
        bus.carry      = full[4];
        bus.mode       = m;
        bus.a_msb      = a[3];
        bus.b_msb      = b[3];
        bus.out_ready  = ordy;
        bus.clr_sticky = clr;
        #1;
        checks++;
        if (bus.out_valid !== (q.size() != 0))
            $display("FAIL out_valid: got %b exp %b", bus.out_valid, (q.size() != 0));
        checks++;
        if (bus.in_ready !== (q.size() < DEPTH)) begin
            errors++;
            $display("FAIL in_ready: got %b exp %b", bus.in_ready, (q.size() < DEPTH));
        end
        if (bus.out_valid !== (q.size() != 0)) errors++;
        popped = 8'h00;
        if (q.size() > 0) begin
            got = {bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
            checks++;
            if (got !== q[0]) begin
                errors++;
                $display("FAIL head_entry: got %h exp %h", got, q[0]);
            end
        end
        do_pop  = (q.size() > 0) && ordy;
        do_push = iv && (q.size() < DEPTH);
        if (do_pop) popped = q.pop_front();
        if (do_push) q.push_back(model(a, b, m));
        @(posedge clk);
        if (do_pop && popped[0]) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
        if (do_pop) m_count = m_count + 8'd1;
        @(negedge clk);
        checks++;
        if (bus.sticky_v !== m_sticky) begin
            errors++;
            $display("FAIL sticky_v: got %b exp %b", bus.sticky_v, m_sticky);
        end
        checks++;
        if (bus.res_count !== m_count) begin
            errors++;
            $display("FAIL res_count: got %0d exp %0d", bus.res_count, m_count);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.clr_sticky = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %b exp 0", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.sticky_v, bus.res_count} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: got ov=%b sv=%b cnt=%0d exp 0/0/0",
                     bus.out_valid, bus.sticky_v, bus.res_count);
        end
        checks++;
        if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== 8'h00) begin
            errors++;
            $display("FAIL reset_result_flags: got %h exp 00",
                     {bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_high: got %b exp 1", bus.in_ready);
        end
        q.delete();
        m_sticky = 1'b0;
        m_count  = 8'd0;
    endtask

    task automatic test_flags;
        step(1'b1, 4'd7, 4'd5, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.out_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== 9'b1_1100_0101) begin
            errors++;
            $display("FAIL add_7_5: got %b exp 111000101",
                     {bus.out_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v});
        end
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.sticky_v, bus.res_count} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL add_7_5_status: got sv=%b cnt=%0d exp 1/1", bus.sticky_v, bus.res_count);
        end
        step(1'b1, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== 8'b0000_1000) begin
            errors++;
            $display("FAIL sub_3_3: got %b exp 00001000",
                     {bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v});
        end
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== 8'b1101_0110) begin
            errors++;
            $display("FAIL sub_2_5: got %b exp 11010110",
                     {bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v});
        end
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_full: got in_ready=%b exp 0", bus.in_ready);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_throughput;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.res_count !== 8'd44) begin
            errors++;
            $display("FAIL throughput_wrap: got %0d exp 44", bus.res_count);
        end
    endtask

    task automatic test_reset_midflight;
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'd7, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd7, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.sticky_v !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: got %b exp 1", bus.sticky_v);
        end
        step(1'b1, 4'd7, 4'd5, 1'b0, 1'b0, 1'b0);
        test_reset();
        step(1'b1, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        m_sticky       = 1'b0;
        m_count        = 8'd0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.sum        = 4'd0;
        bus.carry      = 1'b0;
        bus.mode       = 1'b0;
        bus.a_msb      = 1'b0;
        bus.b_msb      = 1'b0;
        bus.out_ready  = 1'b0;
        bus.clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_flags();
        test_backpressure();
        test_reset();
        test_throughput();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
